dds_ctrl_regs: RTL and testbench

//  Parametrised front-panel control for the N-channel DDS core. Debounces active-low keys and

---
 rtl/dds_ctrl_regs_if.sv | 21 ++
 rtl/dds_ctrl_regs.sv | 197 +++++++++++++++++++
 tb/tb_dds_ctrl_regs.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_ctrl_regs_if.sv
// Control bus from the front-panel register block to the per-channel DDS phase accumulators and wave ROMs.
// Channel k occupies slice [k*W +: W] of each per-channel vector.
interface dds_ctrl_regs_if #(
   parameter int NUM_CH  = 2,
   parameter int FREQ_W  = 32,
   parameter int PHASE_W = 10
);
   logic [NUM_CH*4-1:0]       wave_select;
   logic [NUM_CH*FREQ_W-1:0]  freq_ctrl;
   logic [NUM_CH*PHASE_W-1:0] phase_ctrl;
   logic                      phase_sync;
   logic                      busy;

   modport master (
      output wave_select, freq_ctrl, phase_ctrl, phase_sync, busy
   );

   modport slave (
      input wave_select, freq_ctrl, phase_ctrl, phase_sync, busy
   );
endinterface

// File: rtl/dds_ctrl_regs.sv
// Debounced key front panel staging per-channel DDS frequency/phase/wave; commit applies freq+phase atomically.
// Latency: commit event to new outputs 2*DATA_W+2 cycles; no backpressure, a commit arriving while busy is dropped.
module dds_ctrl_regs #(
   parameter int NUM_CH     = 2,
   parameter int DATA_W     = 8,
   parameter int FREQ_W     = 32,
   parameter int PHASE_W    = 10,
   parameter int FREQ_SCALE = 179,
   parameter int RST_FREQ   = 1000,
   parameter int DEB_CNT    = 240000,
   localparam int CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [CW-1:0]     ch_sel,
   input  logic              key_wave,
   input  logic              key_fre_h,
   input  logic              key_fre_l,
   input  logic              key_pha,
   input  logic              key_commit,
   input  logic [DATA_W-1:0] data_in,
   dds_ctrl_regs_if.master   ctrl
);
   localparam int CODE_W = 2 * DATA_W;
   localparam int DW     = $clog2(DEB_CNT + 1);
   localparam int MW     = $clog2(CODE_W + 1);
   localparam logic [FREQ_W-1:0] RST_WORD = FREQ_W'(longint'(RST_FREQ) * longint'(FREQ_SCALE));

   typedef enum logic [1:0] {IDLE, MUL, LOAD} state_t;

   logic [4:0]        key_raw, key_s1, key_s2, key_ev;
   logic [CW-1:0]     ch_s1, ch_s2;
   logic [DATA_W-1:0] dat_s1, dat_s2;

   assign key_raw = {key_commit, key_pha, key_fre_l, key_fre_h, key_wave};

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         key_s1 <= '1;
         key_s2 <= '1;
         ch_s1  <= '0;
         ch_s2  <= '0;
         dat_s1 <= '0;
         dat_s2 <= '0;
      end else begin
         key_s1 <= key_raw;
         key_s2 <= key_s1;
         ch_s1  <= ch_sel;
         ch_s2  <= ch_s1;
         dat_s1 <= data_in;
         dat_s2 <= dat_s1;
      end
   end

   // A key only changes accepted level after DEB_CNT consecutive differing samples.
   for (genvar k = 0; k < 5; k++) begin : g_deb
      logic [DW-1:0] cnt;
      logic          acc;
      logic          hit;

      assign hit = (key_s2[k] != acc) && (cnt == DW'(DEB_CNT - 1));

      always_ff @(posedge sys_clk) begin
         if (sys_rst) begin
            cnt <= '0;
            acc <= 1'b1;
         end else if (key_s2[k] == acc) begin
            cnt <= '0;
         end else if (hit) begin
            cnt <= '0;
            acc <= key_s2[k];
         end else begin
            cnt <= cnt + DW'(1);
         end
      end

      assign key_ev[k] = hit & acc;
   end

   logic ch_ok;
   logic ev_wave, ev_fre_h, ev_fre_l, ev_pha, ev_commit;

   assign ch_ok     = 32'(ch_s2) < NUM_CH;
   assign ev_wave   = key_ev[0] & ch_ok;
   assign ev_fre_h  = key_ev[1] & ch_ok;
   assign ev_fre_l  = key_ev[2] & ~key_ev[1] & ch_ok;
   assign ev_pha    = key_ev[3] & ch_ok;
   assign ev_commit = key_ev[4] & ch_ok;

   function automatic logic [3:0] wave_next(input logic [3:0] w);
      case (w)
         4'd0:    wave_next = 4'd1;
         4'd1:    wave_next = 4'd2;
         4'd2:    wave_next = 4'd4;
         4'd4:    wave_next = 4'd8;
         default: wave_next = 4'd0;
      endcase
   endfunction

   logic [NUM_CH-1:0][3:0]         wave_q;
   logic [NUM_CH-1:0][CODE_W-1:0]  stage_code;
   logic [NUM_CH-1:0][PHASE_W-1:0] stage_pha;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wave_q     <= '0;
         stage_code <= {NUM_CH{CODE_W'(RST_FREQ)}};
         stage_pha  <= '0;
      end else begin
         if (ev_wave)
            wave_q[ch_s2] <= wave_next(wave_q[ch_s2]);
         if (ev_fre_h)
            stage_code[ch_s2][CODE_W-1 -: DATA_W] <= dat_s2;
         else if (ev_fre_l)
            stage_code[ch_s2][DATA_W-1:0] <= dat_s2;
         if (ev_pha)
            stage_pha[ch_s2] <= PHASE_W'(dat_s2) << (PHASE_W - DATA_W);
      end
   end

   state_t state_q, state_d;
   logic [MW-1:0] mul_cnt;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ev_commit) state_d = MUL;
         MUL:     if (mul_cnt == MW'(CODE_W - 1)) state_d = LOAD;
         LOAD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   logic [CW-1:0]                  snap_ch;
   logic [PHASE_W-1:0]             snap_pha;
   logic [CODE_W-1:0]              mul_code;
   logic [FREQ_W-1:0]              mul_cand, prod;
   logic [NUM_CH-1:0][FREQ_W-1:0]  freq_q;
   logic [NUM_CH-1:0][PHASE_W-1:0] phase_q;
   logic                           sync_q, all_eq;

   // Accumulators are cleared only when the new word makes every channel identical.
   always_comb begin
      all_eq = 1'b1;
      for (int i = 0; i < NUM_CH; i++)
         if (CW'(i) != snap_ch && freq_q[i] != prod) all_eq = 1'b0;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         snap_ch  <= '0;
         snap_pha <= '0;
         mul_code <= '0;
         mul_cand <= '0;
         prod     <= '0;
         mul_cnt  <= '0;
         freq_q   <= {NUM_CH{RST_WORD}};
         phase_q  <= '0;
         sync_q   <= 1'b0;
      end else begin
         sync_q <= 1'b0;
         case (state_q)
            IDLE: if (ev_commit) begin
               snap_ch  <= ch_s2;
               snap_pha <= stage_pha[ch_s2];
               mul_code <= stage_code[ch_s2];
               mul_cand <= FREQ_W'(FREQ_SCALE);
               prod     <= '0;
               mul_cnt  <= '0;
            end
            MUL: begin
               if (mul_code[0]) prod <= prod + mul_cand;
               mul_cand <= mul_cand << 1;
               mul_code <= mul_code >> 1;
               mul_cnt  <= mul_cnt + MW'(1);
            end
            LOAD: begin
               freq_q[snap_ch]  <= prod;
               phase_q[snap_ch] <= snap_pha;
               sync_q           <= all_eq;
            end
            default: ;
         endcase
      end
   end

   assign ctrl.wave_select = wave_q;
   assign ctrl.freq_ctrl   = freq_q;
   assign ctrl.phase_ctrl  = phase_q;
   assign ctrl.phase_sync  = sync_q;
   assign ctrl.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_dds_ctrl_regs.sv
// Bench for dds_ctrl_regs with three channels and a short debounce: fixed vectors, corner sequences, random ops.
module tb_dds_ctrl_regs;
   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic [1:0] ch_sel;
   logic [4:0] keys;
   logic [7:0] data_in;

   always #5 sys_clk = ~sys_clk;

   dds_ctrl_regs_if #(.NUM_CH(3), .FREQ_W(32), .PHASE_W(10)) ctrl ();

   dds_ctrl_regs #(.NUM_CH(3), .DATA_W(8), .FREQ_W(32), .PHASE_W(10), .FREQ_SCALE(179),
                   .RST_FREQ(1000), .DEB_CNT(4)) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .ch_sel     (ch_sel),
      .key_wave   (keys[0]),
      .key_fre_h  (keys[1]),
      .key_fre_l  (keys[2]),
      .key_pha    (keys[3]),
      .key_commit (keys[4]),
      .data_in    (data_in),
      .ctrl       (ctrl)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: per-channel settings as plain arrays.
   logic [3:0]  m_wave[3];
   logic [15:0] m_code[3];
   logic [9:0]  m_spha[3];
   logic [31:0] m_freq[3];
   logic [9:0]  m_pha[3];

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_wave[i] = 4'd0;
         m_code[i] = 16'd1000;
         m_spha[i] = 10'd0;
         m_freq[i] = 32'd179000;
         m_pha[i]  = 10'd0;
      end
   endtask

   function automatic logic [3:0] wave_after(input logic [3:0] w);
      int seq[5] = '{0, 1, 2, 4, 8};
      wave_after = 4'd0;
      for (int i = 0; i < 5; i++)
         if (seq[i] == int'(w)) wave_after = 4'(seq[(i + 1) % 5]);
   endfunction

   task automatic model_op(input int kind, input int ch, input logic [7:0] d,
                           output int eb, output int es);
      logic [31:0] w;
      eb = 0;
      es = 0;
      if (ch >= 3) return;
      case (kind)
         0: m_wave[ch] = wave_after(m_wave[ch]);
         1: m_code[ch] = 16'(int'(d) * 256 + int'(m_code[ch]) % 256);
         2: m_code[ch] = 16'((int'(m_code[ch]) / 256) * 256 + int'(d));
         3: m_spha[ch] = 10'(int'(d) * 4);
         default: begin
            w  = 32'(64'(m_code[ch]) * 64'd179);
            eb = 17;
            es = 1;
            for (int i = 0; i < 3; i++)
               if (i != ch && m_freq[i] != w) es = 0;
            m_freq[ch] = w;
            m_pha[ch]  = m_spha[ch];
         end
      endcase
   endtask

   function automatic logic [11:0] mv_wave();
      for (int i = 0; i < 3; i++) mv_wave[i*4 +: 4] = m_wave[i];
   endfunction
   function automatic logic [95:0] mv_freq();
      for (int i = 0; i < 3; i++) mv_freq[i*32 +: 32] = m_freq[i];
   endfunction
   function automatic logic [29:0] mv_pha();
      for (int i = 0; i < 3; i++) mv_pha[i*10 +: 10] = m_pha[i];
   endfunction

   int          r_busy, r_sync;
   logic        r_sync_at;
   logic [31:0] r_flast;

   // Press one key for six cycles and observe the bus for 40 cycles.
   task automatic apply_op(input int kind, input int ch, input logic [7:0] d);
      logic pb;
      pb        = 1'b0;
      r_busy    = 0;
      r_sync    = 0;
      r_sync_at = 1'b0;
      r_flast   = '0;
      ch_sel    = 2'(ch);
      data_in   = d;
      keys      = 5'h1F & ~(5'b1 << kind);
      for (int c = 0; c < 40; c++) begin
         @(negedge sys_clk);
         if (c == 5) keys = 5'h1F;
         if (ctrl.busy) begin
            r_busy++;
            if (ch < 3) r_flast = ctrl.freq_ctrl[ch*32 +: 32];
         end
         if (pb && !ctrl.busy) r_sync_at = ctrl.phase_sync;
         if (ctrl.phase_sync) r_sync++;
         pb = ctrl.busy;
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, "_wave"}, 128'(ctrl.wave_select), 128'(mv_wave()));
      check({tag, "_freq"}, 128'(ctrl.freq_ctrl), 128'(mv_freq()));
      check({tag, "_phase"}, 128'(ctrl.phase_ctrl), 128'(mv_pha()));
      check({tag, "_idle"}, 128'(ctrl.busy), 128'(0));
   endtask

   task automatic do_op(input int kind, input int ch, input logic [7:0] d, input string tag);
      logic [31:0] old_f;
      int eb, es;
      old_f = (ch < 3) ? m_freq[ch] : 32'd0;
      model_op(kind, ch, d, eb, es);
      apply_op(kind, ch, d);
      check_state(tag);
      if (kind == 4) begin
         check({tag, "_busy_cycles"}, 128'(r_busy), 128'(eb));
         check({tag, "_sync_pulses"}, 128'(r_sync), 128'(es));
         if (eb > 0) begin
            check({tag, "_sync_timing"}, 128'(r_sync_at), 128'(es));
            check({tag, "_old_during_load"}, 128'(r_flast), 128'(old_f));
         end
      end
   endtask

   typedef struct {
      int          kind;
      int          ch;
      logic [7:0]  d;
      int          chk;
      logic [3:0]  wave;
      logic [31:0] freq;
      logic [9:0]  pha;
      int          busy;
      int          sync;
   } vec_t;

   vec_t tv[18];

   initial begin
      int bn;
      logic seen;
      tv[0]  = '{1, 1, 8'h07, 1, 4'd0, 32'd179000, 10'd0,   0,  0};
      tv[1]  = '{2, 1, 8'hD0, 1, 4'd0, 32'd179000, 10'd0,   0,  0};
      tv[2]  = '{4, 1, 8'h00, 1, 4'd0, 32'd358000, 10'd0,   17, 0};
      tv[3]  = '{0, 0, 8'h00, 0, 4'd1, 32'd179000, 10'd0,   0,  0};
      tv[4]  = '{0, 0, 8'h00, 0, 4'd2, 32'd179000, 10'd0,   0,  0};
      tv[5]  = '{0, 0, 8'h00, 0, 4'd4, 32'd179000, 10'd0,   0,  0};
      tv[6]  = '{0, 0, 8'h00, 0, 4'd8, 32'd179000, 10'd0,   0,  0};
      tv[7]  = '{0, 0, 8'h00, 0, 4'd0, 32'd179000, 10'd0,   0,  0};
      tv[8]  = '{1, 1, 8'h03, 1, 4'd0, 32'd358000, 10'd0,   0,  0};
      tv[9]  = '{2, 1, 8'hE8, 1, 4'd0, 32'd358000, 10'd0,   0,  0};
      tv[10] = '{3, 1, 8'h40, 1, 4'd0, 32'd358000, 10'd0,   0,  0};
      tv[11] = '{4, 1, 8'h00, 1, 4'd0, 32'd179000, 10'd256, 17, 1};
      tv[12] = '{2, 1, 8'hD0, 1, 4'd0, 32'd179000, 10'd256, 0,  0};
      tv[13] = '{4, 1, 8'h00, 1, 4'd0, 32'd174704, 10'd256, 17, 0};
      tv[14] = '{0, 3, 8'h00, 0, 4'd0, 32'd179000, 10'd0,   0,  0};
      tv[15] = '{1, 3, 8'hFF, 2, 4'd0, 32'd179000, 10'd0,   0,  0};
      tv[16] = '{4, 3, 8'h00, 2, 4'd0, 32'd179000, 10'd0,   0,  0};
      tv[17] = '{0, 2, 8'h00, 2, 4'd1, 32'd179000, 10'd0,   0,  0};

      sys_rst = 1'b1;
      keys    = 5'h1F;
      ch_sel  = 2'd0;
      data_in = 8'h00;
      repeat (3) @(negedge sys_clk);
      sys_rst = 1'b0;
      @(negedge sys_clk);
      model_reset();
      check("reset_freq", 128'(ctrl.freq_ctrl), 128'({3{32'd179000}}));
      check("reset_wave", 128'(ctrl.wave_select), 128'(0));
      check("reset_phase", 128'(ctrl.phase_ctrl), 128'(0));
      check("reset_busy", 128'(ctrl.busy), 128'(0));
      check("reset_sync", 128'(ctrl.phase_sync), 128'(0));

      for (int i = 0; i < 18; i++) begin
         do_op(tv[i].kind, tv[i].ch, tv[i].d, $sformatf("tbl%0d", i));
         check($sformatf("tbl%0d_vec_wave", i), 128'(ctrl.wave_select[tv[i].chk*4 +: 4]), 128'(tv[i].wave));
         check($sformatf("tbl%0d_vec_freq", i), 128'(ctrl.freq_ctrl[tv[i].chk*32 +: 32]), 128'(tv[i].freq));
         check($sformatf("tbl%0d_vec_phase", i), 128'(ctrl.phase_ctrl[tv[i].chk*10 +: 10]), 128'(tv[i].pha));
         if (tv[i].kind == 4) begin
            check($sformatf("tbl%0d_vec_busy", i), 128'(r_busy), 128'(tv[i].busy));
            check($sformatf("tbl%0d_vec_sync", i), 128'(r_sync), 128'(tv[i].sync));
         end
      end

      // A three-cycle low glitch on the wave key must not step the waveform.
      ch_sel = 2'd0;
      keys[0] = 1'b0;
      repeat (3) @(negedge sys_clk);
      keys[0] = 1'b1;
      repeat (12) @(negedge sys_clk);
      check("glitch_wave", 128'(ctrl.wave_select), 128'(mv_wave()));

      // Commit, then a second commit plus a low-byte write while the first is still multiplying.
      do_op(2, 0, 8'h10, "pre_drop");
      ch_sel  = 2'd0;
      data_in = 8'h20;
      bn = 0;
      fork
         begin
            keys[4] = 1'b0;
            repeat (6) @(negedge sys_clk);
            keys[4] = 1'b1;
            repeat (6) @(negedge sys_clk);
            keys[4] = 1'b0;
            keys[2] = 1'b0;
            repeat (6) @(negedge sys_clk);
            keys[4] = 1'b1;
            keys[2] = 1'b1;
         end
         begin
            repeat (45) begin
               @(negedge sys_clk);
               if (ctrl.busy) bn++;
            end
         end
      join
      begin
         int eb, es;
         model_op(4, 0, 8'h00, eb, es);
         model_op(2, 0, 8'h20, eb, es);
      end
      check("drop_busy_cycles", 128'(bn), 128'(17));
      check("drop_snapshot_freq", 128'(ctrl.freq_ctrl[31:0]), 128'(32'd140336));
      check_state("drop");
      do_op(4, 0, 8'h00, "after_drop");
      check("after_drop_freq", 128'(ctrl.freq_ctrl[31:0]), 128'(32'd143200));

      // Reset in the middle of a multiply.
      ch_sel  = 2'd1;
      keys[4] = 1'b0;
      repeat (6) @(negedge sys_clk);
      keys[4] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
         if (ctrl.busy) seen = 1'b1;
         else @(negedge sys_clk);
      end
      check("rst_mul_started", 128'(seen), 128'(1));
      repeat (3) @(negedge sys_clk);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      sys_rst = 1'b0;
      model_reset();
      check("rst_mul_busy", 128'(ctrl.busy), 128'(0));
      check("rst_mul_freq", 128'(ctrl.freq_ctrl), 128'({3{32'd179000}}));
      check_state("rst_mul");
      repeat (30) @(negedge sys_clk);
      check("rst_mul_no_late_write", 128'(ctrl.freq_ctrl), 128'({3{32'd179000}}));
      check("rst_mul_no_sync", 128'(ctrl.phase_sync), 128'(0));

      for (int n = 0; n < 60; n++)
         do_op($urandom_range(0, 4), $urandom_range(0, 3), 8'($urandom_range(0, 255)),
               $sformatf("rnd%0d", n));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end
endmodule
